// File: rtl/data_port_arbiter_if.sv
// One req/gnt/rvalid data-RAM port. The master modport drives the request side
// and the slave modport answers it.
interface data_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    req;
   logic                    gnt;
   logic                    rvalid;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    we;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH-1:0]   rdata;

   modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_port_arbiter.sv
// Two-master arbiter for one in-order data-RAM port, with an owner FIFO routing responses back.
// Optional ARB_ROUND_ROBIN_EN selects alternating conflict resolution; default is M0 fixed priority.
module data_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_OUTST  = 2
) (
   input  logic                clk,
   input  logic                rst,
   data_port_arbiter_if.slave  m0,
   data_port_arbiter_if.slave  m1,
   data_port_arbiter_if.master slv,
   output logic                resp_err
);
   localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTST - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTST);

   logic [MAX_OUTST-1:0] owner_q, owner_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      occ_q, occ_d;
   logic                 lock_q, lock_d, lock_id_q, lock_id_d;
   logic                 resp_err_q, resp_err_d;
   logic                 full, empty, pop, push, elig0, elig1;
   logic                 win_valid, win_id, pref, head, act;

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_q, rr_d;
   assign pref = rr_q;
   assign rr_d = push ? ~win_id : rr_q;
`else
   assign pref = 1'b0;
`endif

   // A pop this cycle frees a slot, so a full FIFO may still accept a push.
   assign full  = (occ_q == CntFull);
   assign empty = (occ_q == '0);
   assign pop   = slv.rvalid & ~empty;
   assign elig0 = m0.req & (~full | pop);
   assign elig1 = m1.req & (~full | pop);

   always_comb begin
      win_valid = 1'b0;
      win_id    = 1'b0;
      if (lock_q) begin
         win_valid = lock_id_q ? elig1 : elig0;
         win_id    = lock_id_q;
      end else if (elig0 & elig1) begin
         win_valid = 1'b1;
         win_id    = pref;
      end else if (elig0 | elig1) begin
         win_valid = 1'b1;
         win_id    = elig1;
      end
   end

   assign push = win_valid & slv.gnt;
   assign head = owner_q[rd_ptr_q];
   assign act  = win_valid & ~rst;

   assign slv.req   = act;
   assign slv.addr  = act ? (win_id ? m1.addr  : m0.addr)  : '0;
   assign slv.we    = act & (win_id ? m1.we : m0.we);
   assign slv.be    = act ? (win_id ? m1.be    : m0.be)    : '0;
   assign slv.wdata = act ? (win_id ? m1.wdata : m0.wdata) : '0;

   assign m0.gnt    = act & ~win_id & slv.gnt;
   assign m1.gnt    = act &  win_id & slv.gnt;
   assign m0.rvalid = pop & ~head & ~rst;
   assign m1.rvalid = pop &  head & ~rst;
   assign m0.rdata  = m0.rvalid ? slv.rdata : '0;
   assign m1.rdata  = m1.rvalid ? slv.rdata : '0;
   assign resp_err  = resp_err_q & ~rst;

   always_comb begin
      owner_d    = owner_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      resp_err_d = resp_err_q | (slv.rvalid & empty);
      // Hold the stalled winner so its attributes stay stable until granted.
      lock_d     = win_valid & ~slv.gnt;
      lock_id_d  = win_id;
      if (push) begin
         owner_d[wr_ptr_q] = win_id;
         wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         lock_q     <= 1'b0;
         lock_id_q  <= 1'b0;
         resp_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_q       <= 1'b0;
`endif
      end else begin
         owner_q    <= owner_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         lock_q     <= lock_d;
         lock_id_q  <= lock_id_d;
         resp_err_q <= resp_err_d;
`ifdef ARB_ROUND_ROBIN_EN
         rr_q       <= rr_d;
`endif
      end
   end
endmodule
